// File: rtl/simd_core.sv
// simd_core: registered 4-lane SIMD integer ALU (ADD/MUL/SUB/AND); define SIMD_CORE_SAT_EN for saturating ADD/SUB
module simd_core #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              opcode,
    input  logic [LANES*LANE_W-1:0] src_a,
    input  logic [LANES*LANE_W-1:0] src_b,
    output logic [LANES*LANE_W-1:0] result
);
    logic [LANES*LANE_W-1:0] nxt;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0] a, b, add, sub, mul;
        assign a = src_a[i*LANE_W +: LANE_W];
        assign b = src_b[i*LANE_W +: LANE_W];
        assign mul = a * b;
`ifdef SIMD_CORE_SAT_EN
        logic [LANE_W:0] sum, diff;
        assign sum  = {1'b0, a} + {1'b0, b};
        assign diff = {1'b0, a} - {1'b0, b};
        assign add  = sum[LANE_W] ? '1 : sum[LANE_W-1:0];
        assign sub  = diff[LANE_W] ? '0 : diff[LANE_W-1:0];
`else
        assign add = a + b;
        assign sub = a - b;
`endif
        assign nxt[i*LANE_W +: LANE_W] = opcode == 2'b00 ? add :
                                         opcode == 2'b01 ? mul :
                                         opcode == 2'b10 ? sub : a & b;
    end

    // capture the lane results; async clear while reset is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) result <= '0;
        else        result <= nxt;
    end
endmodule

// File: tb/tb_simd_core.sv
// tb_simd_core: randomized self-checking bench for simd_core against a per-lane arithmetic model
module tb_simd_core;
    localparam int LANES = 4;
    localparam int LANE_W = 32;
    localparam int W = LANES * LANE_W;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   opcode = 2'b00;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic [W-1:0] result;
    int           n_chk = 0;
    int           n_fail = 0;

    simd_core #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .src_a(src_a), .src_b(src_b), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        longint unsigned x, y, z, mx;
        mx = (64'd1 << LANE_W) - 1;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            x = 64'(a[i*LANE_W +: LANE_W]);
            y = 64'(b[i*LANE_W +: LANE_W]);
            case (op)
                2'd0: begin
                    z = x + y;
`ifdef SIMD_CORE_SAT_EN
                    if (z > mx) z = mx;
`endif
                end
                2'd1: z = x * y;
                2'd2: begin
`ifdef SIMD_CORE_SAT_EN
                    z = (x < y) ? 0 : x - y;
`else
                    z = x - y;
`endif
                end
                default: z = x & y;
            endcase
            z = z & mx;
            r[i*LANE_W +: LANE_W] = z[LANE_W-1:0];
        end
        return r;
    endfunction

    function automatic logic [LANE_W-1:0] pick();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return LANE_W'($urandom_range(0, 15));
            3: return {1'b1, LANE_W'($urandom) >> 1};
            default: return LANE_W'($urandom);
        endcase
    endfunction

    task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp);
        opcode = op;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        check(tag, result, exp);
    endtask

    initial begin
        logic [W-1:0] wrap_exp, sub0_exp, ra, rb;
        logic [1:0]   rop;
        // reset held with live operands
        opcode = 2'b00;
        src_a = {4{32'h1234_5678}};
        src_b = {4{32'h0101_0101}};
        #1;
        check("reset_initial", result, '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", result, '0);
        end
        #2 reset = 1'b1;

        do_op("add", 2'b00, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10},
              {32'd44, 32'd33, 32'd22, 32'd11});
        do_op("mul", 2'b01, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd5, 32'd6, 32'd7, 32'd8},
              {32'd20, 32'd18, 32'd14, 32'd8});
        do_op("mul_trunc", 2'b01, {32'd4, 32'd3, 32'd2, 32'h0001_0000}, {32'd5, 32'd6, 32'd7, 32'h0001_0000},
              {32'd20, 32'd18, 32'd14, 32'd0});
`ifdef SIMD_CORE_SAT_EN
        sub0_exp = {32'd7, 32'd0, 32'd0, 32'hF0};
        wrap_exp = {32'd9, 32'd7, 32'd5, 32'hFFFF_FFFF};
`else
        sub0_exp = {32'd7, 32'd0, 32'hFFFF_FFFF, 32'hF0};
        wrap_exp = {32'd9, 32'd7, 32'd5, 32'd0};
`endif
        do_op("sub", 2'b10, {32'd10, 32'd5, 32'd0, 32'hFF}, {32'd3, 32'd5, 32'd1, 32'h0F}, sub0_exp);
        do_op("and", 2'b11, {32'd10, 32'd5, 32'd0, 32'hFF}, {32'd3, 32'd5, 32'd1, 32'h0F},
              {32'd2, 32'd5, 32'd0, 32'h0F});
        do_op("add_wrap", 2'b00, {32'd4, 32'd3, 32'd2, 32'hFFFF_FFFF}, {32'd5, 32'd4, 32'd3, 32'd1}, wrap_exp);

        // result must hold between edges
        #4;
        check("hold", result, wrap_exp);

        // asynchronous assertion between edges
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("reset_async", result, '0);
        @(posedge clk);
        #1;
        check("reset_async_hold", result, '0);
        #3 reset = 1'b1;
        do_op("after_reset", 2'b00, {32'd1, 32'd1, 32'd1, 32'd1}, {32'd2, 32'd2, 32'd2, 32'd2},
              {32'd3, 32'd3, 32'd3, 32'd3});

        // back-to-back random operations, a new one every cycle
        for (int n = 0; n < 400; n++) begin
            rop = (n < 8) ? 2'(n) : 2'($urandom_range(0, 3));
            for (int i = 0; i < LANES; i++) begin
                ra[i*LANE_W +: LANE_W] = pick();
                rb[i*LANE_W +: LANE_W] = pick();
            end
            do_op($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb, model(rop, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
